// File: rtl/tl_ul_responder.sv
// TL-UL slave with one outstanding transaction, backed by a 64-bit word memory.
// Define TLUL_RESP_RANGE_CHECK_EN to deny accesses outside the memory window.
module tl_ul_responder #(
    parameter logic [31:0] BASE_ADDR    = 32'h8000_0000,
    parameter int unsigned MEM_DEPTH    = 256,
    parameter int          RESP_LATENCY = 2
) (
    input  logic        clock,
    input  logic        reset,

    input  logic        a_valid,
    input  logic [2:0]  a_bits_opcode,
    input  logic [2:0]  a_bits_param,
    input  logic [3:0]  a_bits_size,
    input  logic [1:0]  a_bits_source,
    input  logic [31:0] a_bits_address,
    input  logic [7:0]  a_bits_mask,
    input  logic [63:0] a_bits_data,
    output logic        a_ready,

    output logic        d_valid,
    output logic [2:0]  d_bits_opcode,
    output logic [1:0]  d_bits_param,
    output logic [3:0]  d_bits_size,
    output logic [1:0]  d_bits_source,
    output logic [1:0]  d_bits_sink,
    output logic        d_bits_denied,
    output logic [63:0] d_bits_data,
    output logic        d_bits_corrupt,
    input  logic        d_ready,

    output logic [31:0] txn_count,
    output logic [15:0] err_count
);

    localparam int unsigned IdxW    = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
    localparam int          Latency = (RESP_LATENCY < 1) ? 1 : RESP_LATENCY;

    localparam logic [2:0] OpPutFull     = 3'd0;
    localparam logic [2:0] OpPutPartial  = 3'd1;
    localparam logic [2:0] OpGet         = 3'd4;
    localparam logic [2:0] AccessAck     = 3'd0;
    localparam logic [2:0] AccessAckData = 3'd1;

    typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

    state_e      state_q;
    logic [31:0] lat_q;
    logic        d_valid_q;
    logic [2:0]  d_opcode_q;
    logic [3:0]  d_size_q;
    logic [1:0]  d_source_q;
    logic        d_denied_q;
    logic        d_corrupt_q;
    logic [63:0] d_data_q;
    logic [31:0] txn_q;
    logic [15:0] err_q;

    logic [63:0] mem [MEM_DEPTH];

    logic [31:0]     offset;
    logic [IdxW-1:0] idx;
    logic            in_range;
    logic            is_get;
    logic            is_put;
    logic            denied;
    logic            accept;
    logic            unused_a_param;

    assign unused_a_param = ^a_bits_param;

    // Offset wraps for addresses below the base, so the range check also catches them.
    assign offset = a_bits_address - BASE_ADDR;
    assign idx    = IdxW'(offset >> 3);

`ifdef TLUL_RESP_RANGE_CHECK_EN
    localparam logic [32:0] WindowBytes = 33'(MEM_DEPTH) << 3;
    assign in_range = ({1'b0, offset} < WindowBytes);
`else
    assign in_range = 1'b1;
`endif

    assign is_get = (a_bits_opcode == OpGet);
    assign is_put = (a_bits_opcode == OpPutFull) || (a_bits_opcode == OpPutPartial);
    assign denied = !(is_get || is_put) || (a_bits_size > 4'd3) || !in_range;

    assign a_ready = (state_q == StIdle) && !reset;
    assign accept  = a_valid && a_ready;

    // Backing store is deliberately left out of reset so committed Puts survive it.
    always_ff @(posedge clock) begin
        if (accept && is_put && !denied) begin
            for (int b = 0; b < 8; b++) begin
                if (a_bits_mask[b]) begin
                    mem[idx][8*b +: 8] <= a_bits_data[8*b +: 8];
                end
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= StIdle;
            lat_q       <= '0;
            d_valid_q   <= 1'b0;
            d_opcode_q  <= '0;
            d_size_q    <= '0;
            d_source_q  <= '0;
            d_denied_q  <= 1'b0;
            d_corrupt_q <= 1'b0;
            d_data_q    <= '0;
            txn_q       <= '0;
            err_q       <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (accept) begin
                        d_opcode_q  <= is_get ? AccessAckData : AccessAck;
                        d_size_q    <= a_bits_size;
                        d_source_q  <= a_bits_source;
                        d_denied_q  <= denied;
                        d_corrupt_q <= is_get && denied;
                        d_data_q    <= (is_get && !denied) ? mem[idx] : '0;
                        if (Latency == 1) begin
                            state_q   <= StResp;
                            d_valid_q <= 1'b1;
                        end else begin
                            state_q <= StWait;
                            lat_q   <= 32'(Latency - 1);
                        end
                    end
                end
                StWait: begin
                    lat_q <= lat_q - 32'd1;
                    if (lat_q == 32'd1) begin
                        state_q   <= StResp;
                        d_valid_q <= 1'b1;
                    end
                end
                StResp: begin
                    if (d_ready) begin
                        state_q   <= StIdle;
                        d_valid_q <= 1'b0;
                        txn_q     <= txn_q + 32'd1;
                        if (d_denied_q) begin
                            err_q <= err_q + 16'd1;
                        end
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign d_valid        = d_valid_q;
    assign d_bits_opcode  = d_opcode_q;
    assign d_bits_param   = '0;
    assign d_bits_size    = d_size_q;
    assign d_bits_source  = d_source_q;
    assign d_bits_sink    = '0;
    assign d_bits_denied  = d_denied_q;
    assign d_bits_data    = d_data_q;
    assign d_bits_corrupt = d_corrupt_q;
    assign txn_count      = txn_q;
    assign err_count      = err_q;

endmodule

// File: tb/tb_tl_ul_responder.sv
// Directed, table-driven bench for tl_ul_responder at the default parameters.
// Expected aliasing/denial of the out-of-window Get follows TLUL_RESP_RANGE_CHECK_EN.
module tb_tl_ul_responder;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        a_valid = 1'b0;
    logic [2:0]  a_bits_opcode = '0;
    logic [2:0]  a_bits_param = '0;
    logic [3:0]  a_bits_size = '0;
    logic [1:0]  a_bits_source = '0;
    logic [31:0] a_bits_address = '0;
    logic [7:0]  a_bits_mask = '0;
    logic [63:0] a_bits_data = '0;
    logic        a_ready;
    logic        d_valid;
    logic [2:0]  d_bits_opcode;
    logic [1:0]  d_bits_param;
    logic [3:0]  d_bits_size;
    logic [1:0]  d_bits_source;
    logic [1:0]  d_bits_sink;
    logic        d_bits_denied;
    logic [63:0] d_bits_data;
    logic        d_bits_corrupt;
    logic        d_ready = 1'b0;
    logic [31:0] txn_count;
    logic [15:0] err_count;

    tl_ul_responder dut (
        .clock          (clock),
        .reset          (reset),
        .a_valid        (a_valid),
        .a_bits_opcode  (a_bits_opcode),
        .a_bits_param   (a_bits_param),
        .a_bits_size    (a_bits_size),
        .a_bits_source  (a_bits_source),
        .a_bits_address (a_bits_address),
        .a_bits_mask    (a_bits_mask),
        .a_bits_data    (a_bits_data),
        .a_ready        (a_ready),
        .d_valid        (d_valid),
        .d_bits_opcode  (d_bits_opcode),
        .d_bits_param   (d_bits_param),
        .d_bits_size    (d_bits_size),
        .d_bits_source  (d_bits_source),
        .d_bits_sink    (d_bits_sink),
        .d_bits_denied  (d_bits_denied),
        .d_bits_data    (d_bits_data),
        .d_bits_corrupt (d_bits_corrupt),
        .d_ready        (d_ready),
        .txn_count      (txn_count),
        .err_count      (err_count)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [2:0]  op;
        logic [3:0]  size;
        logic [1:0]  src;
        logic [31:0] addr;
        logic [7:0]  mask;
        logic [63:0] data;
        int          stall;
        logic [2:0]  e_op;
        logic        e_den;
        logic        e_cor;
        logic [63:0] e_data;
    } vec_t;

    localparam int NVec = 16;
    vec_t vecs[NVec];

    int          n_checks = 0;
    int          n_fail = 0;
    int          cur = -1;
    logic [31:0] exp_txn = '0;
    logic [15:0] exp_err = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL v%0d %s: got %h, expected %h", cur, name, act, exp);
        end
    endtask

    task automatic check_d(input vec_t v);
        check("d_valid", 64'(d_valid), 64'd1);
        check("d_opcode", 64'(d_bits_opcode), 64'(v.e_op));
        check("d_param", 64'(d_bits_param), 64'd0);
        check("d_size", 64'(d_bits_size), 64'(v.size));
        check("d_source", 64'(d_bits_source), 64'(v.src));
        check("d_sink", 64'(d_bits_sink), 64'd0);
        check("d_denied", 64'(d_bits_denied), 64'(v.e_den));
        check("d_corrupt", 64'(d_bits_corrupt), 64'(v.e_cor));
        check("d_data", d_bits_data, v.e_data);
    endtask

    // Wait (bounded) for a_ready at a falling edge, then present a request for one cycle.
    task automatic issue(input vec_t v);
        int n;
        n = 0;
        while (!a_ready && n < 20) begin
            @(negedge clock);
            n++;
        end
        check("a_ready before request", 64'(a_ready), 64'd1);
        a_valid        = 1'b1;
        a_bits_opcode  = v.op;
        a_bits_size    = v.size;
        a_bits_source  = v.src;
        a_bits_address = v.addr;
        a_bits_mask    = v.mask;
        a_bits_data    = v.data;
        @(posedge clock);
        #1;
        // Keep a conflicting full Put on A while busy; it must be ignored.
        a_bits_opcode  = 3'd0;
        a_bits_size    = 4'd3;
        a_bits_mask    = 8'hFF;
        a_bits_data    = ~v.data;
    endtask

    task automatic run_vec(input vec_t v);
        int n;
        issue(v);
        n = 0;
        while (!d_valid && n < 20) begin
            @(negedge clock);
            n++;
            if (!d_valid) check("a_ready in WAIT", 64'(a_ready), 64'd0);
        end
        check("latency", 64'(n), 64'd2);
        for (int i = 0; i < v.stall; i++) begin
            check_d(v);
            check("a_ready in RESP", 64'(a_ready), 64'd0);
            @(negedge clock);
        end
        check_d(v);
        d_ready = 1'b1;
        @(posedge clock);
        #1;
        d_ready = 1'b0;
        a_valid = 1'b0;
        exp_txn = exp_txn + 32'd1;
        if (v.e_den) exp_err = exp_err + 16'd1;
        @(negedge clock);
        check("d_valid after handshake", 64'(d_valid), 64'd0);
        check("a_ready after handshake", 64'(a_ready), 64'd1);
        check("txn_count", 64'(txn_count), 64'(exp_txn));
        check("err_count", 64'(err_count), 64'(exp_err));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t rv;
        // op size src addr mask data stall | e_op e_den e_cor e_data
        vecs[0]  = '{3'd0, 4'd3, 2'd1, 32'h8000_0010, 8'hFF, 64'h1122334455667788, 0,
                     3'd0, 1'b0, 1'b0, 64'h0};
        vecs[1]  = '{3'd4, 4'd3, 2'd2, 32'h8000_0010, 8'hFF, 64'h0, 3,
                     3'd1, 1'b0, 1'b0, 64'h1122334455667788};
        vecs[2]  = '{3'd1, 4'd3, 2'd3, 32'h8000_0010, 8'h0F, 64'hAAAAAAAA_BBBBBBBB, 0,
                     3'd0, 1'b0, 1'b0, 64'h0};
        vecs[3]  = '{3'd4, 4'd3, 2'd0, 32'h8000_0010, 8'hFF, 64'h0, 0,
                     3'd1, 1'b0, 1'b0, 64'h11223344_BBBBBBBB};
        vecs[4]  = '{3'd0, 4'd3, 2'd1, 32'h8000_0000, 8'hFF, 64'hCAFEF00D_DEADBEEF, 0,
                     3'd0, 1'b0, 1'b0, 64'h0};
        vecs[5]  = '{3'd4, 4'd2, 2'd2, 32'h8000_0004, 8'h0F, 64'h0, 0,
                     3'd1, 1'b0, 1'b0, 64'hCAFEF00D_DEADBEEF};
        vecs[6]  = '{3'd2, 4'd3, 2'd3, 32'h8000_0010, 8'hFF, 64'hFFFFFFFF_FFFFFFFF, 1,
                     3'd0, 1'b1, 1'b0, 64'h0};
        vecs[7]  = '{3'd4, 4'd4, 2'd0, 32'h8000_0010, 8'hFF, 64'h0, 0,
                     3'd1, 1'b1, 1'b1, 64'h0};
        vecs[8]  = '{3'd4, 4'd3, 2'd1, 32'h8000_0010, 8'hFF, 64'h0, 0,
                     3'd1, 1'b0, 1'b0, 64'h11223344_BBBBBBBB};
`ifdef TLUL_RESP_RANGE_CHECK_EN
        vecs[9]  = '{3'd4, 4'd3, 2'd2, 32'h9000_0000, 8'hFF, 64'h0, 0,
                     3'd1, 1'b1, 1'b1, 64'h0};
`else
        vecs[9]  = '{3'd4, 4'd3, 2'd2, 32'h9000_0000, 8'hFF, 64'h0, 0,
                     3'd1, 1'b0, 1'b0, 64'hCAFEF00D_DEADBEEF};
`endif
        vecs[10] = '{3'd0, 4'd5, 2'd3, 32'h8000_0000, 8'hFF, 64'h0, 0,
                     3'd0, 1'b1, 1'b0, 64'h0};
        vecs[11] = '{3'd4, 4'd3, 2'd0, 32'h8000_0000, 8'hFF, 64'h0, 0,
                     3'd1, 1'b0, 1'b0, 64'hCAFEF00D_DEADBEEF};
        vecs[12] = '{3'd4, 4'd3, 2'd1, 32'h8000_0018, 8'hFF, 64'h0, 2,
                     3'd1, 1'b0, 1'b0, 64'h55556666_77778888};
        vecs[13] = '{3'd1, 4'd0, 2'd2, 32'h8000_0018, 8'h80, 64'hAB000000_00000000, 0,
                     3'd0, 1'b0, 1'b0, 64'h0};
        vecs[14] = '{3'd4, 4'd1, 2'd3, 32'h8000_0019, 8'hFF, 64'h0, 0,
                     3'd1, 1'b0, 1'b0, 64'hAB556666_77778888};
        vecs[15] = '{3'd7, 4'd2, 2'd0, 32'h8000_0018, 8'hFF, 64'h0, 0,
                     3'd0, 1'b1, 1'b0, 64'h0};

        // Reset state
        repeat (3) @(negedge clock);
        check("reset a_ready", 64'(a_ready), 64'd0);
        check("reset d_valid", 64'(d_valid), 64'd0);
        check("reset d_opcode", 64'(d_bits_opcode), 64'd0);
        check("reset d_size", 64'(d_bits_size), 64'd0);
        check("reset d_source", 64'(d_bits_source), 64'd0);
        check("reset d_denied", 64'(d_bits_denied), 64'd0);
        check("reset d_corrupt", 64'(d_bits_corrupt), 64'd0);
        check("reset d_data", d_bits_data, 64'd0);
        check("reset txn_count", 64'(txn_count), 64'd0);
        check("reset err_count", 64'(err_count), 64'd0);
        reset = 1'b0;
        #1;
        check("a_ready out of reset", 64'(a_ready), 64'd1);
        @(negedge clock);

        // Reset during WAIT: Put is committed, no response appears.
        cur = 100;
        rv = '{3'd0, 4'd3, 2'd1, 32'h8000_0018, 8'hFF, 64'h55556666_77778888, 0,
               3'd0, 1'b0, 1'b0, 64'h0};
        issue(rv);
        a_valid = 1'b0;
        @(negedge clock);
        check("d_valid in WAIT", 64'(d_valid), 64'd0);
        reset = 1'b1;
        @(posedge clock);
        #1;
        check("a_ready during reset", 64'(a_ready), 64'd0);
        check("d_valid during reset", 64'(d_valid), 64'd0);
        @(negedge clock);
        reset = 1'b0;
        #1;
        check("a_ready after reset", 64'(a_ready), 64'd1);
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            check("d_valid after WAIT reset", 64'(d_valid), 64'd0);
            check("txn_count after WAIT reset", 64'(txn_count), 64'd0);
        end

        // Reset during RESP with d_ready high: reset wins, response dropped.
        cur = 101;
        rv = '{3'd4, 4'd3, 2'd2, 32'h8000_0018, 8'hFF, 64'h0, 0,
               3'd1, 1'b0, 1'b0, 64'h55556666_77778888};
        issue(rv);
        a_valid = 1'b0;
        @(negedge clock);
        @(negedge clock);
        check_d(rv);
        reset   = 1'b1;
        d_ready = 1'b1;
        @(posedge clock);
        #1;
        check("d_valid after RESP reset", 64'(d_valid), 64'd0);
        check("d_data after RESP reset", d_bits_data, 64'd0);
        check("txn_count after RESP reset", 64'(txn_count), 64'd0);
        @(negedge clock);
        reset   = 1'b0;
        d_ready = 1'b0;
        @(negedge clock);
        check("d_valid idle after reset", 64'(d_valid), 64'd0);

        // Table-driven transactions
        for (int i = 0; i < NVec; i++) begin
            cur = i;
            run_vec(vecs[i]);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/tl_ul_responder.md
TL_UL_RESPONDER -- requirements
Module: tl_ul_responder

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 32'h8000_0000, byte address of word 0 of the backing store.
REQ-002 SHALL have parameter MEM_DEPTH, default 256, number of 64-bit words; power of two.
REQ-003 SHALL have parameter RESP_LATENCY, default 2, cycles from A acceptance to D valid; values below 1 treated as 1.
REQ-004 SHALL have port clock  input  1  sole clock; all logic on rising edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have A-channel inputs a_valid 1, a_bits_opcode 3, a_bits_param 3, a_bits_size 4, a_bits_source 2, a_bits_address 32, a_bits_mask 8, a_bits_data 64; output a_ready 1.
REQ-007 SHALL have D-channel outputs d_valid 1, d_bits_opcode 3, d_bits_param 2, d_bits_size 4, d_bits_source 2, d_bits_sink 2, d_bits_denied 1, d_bits_data 64, d_bits_corrupt 1; input d_ready 1.
REQ-008 SHALL have outputs txn_count 32 (D handshakes completed) and err_count 16 (D handshakes with denied=1).

Function
REQ-009 SHALL implement FSM IDLE -> WAIT -> RESP -> IDLE; one outstanding transaction.
REQ-010 SHALL drive a_ready=1 only in IDLE with reset low; acceptance = a_valid && a_ready.
REQ-011 SHALL on acceptance latch source, size, opcode and response fields; go to WAIT with latency counter = RESP_LATENCY-1, or directly to RESP when RESP_LATENCY=1.
REQ-012 SHALL decrement the counter each WAIT cycle; enter RESP when it reaches 0; d_valid first high exactly RESP_LATENCY cycles after the acceptance edge.
REQ-013 SHALL in RESP hold d_valid=1 and all d_bits stable until d_valid && d_ready, then return to IDLE; next a_ready the following cycle.
REQ-014 SHALL decode: Get(4) -> AccessAckData(1); PutFullData(0)/PutPartialData(1) -> AccessAck(0); any other opcode -> AccessAck(0) with denied=1, no memory access.
REQ-015 SHALL deny (denied=1, no memory access) any request with a_bits_size > 3.
REQ-016 SHALL index memory by ((a_bits_address - BASE_ADDR) >> 3) modulo MEM_DEPTH; address bits [2:0] ignored.
REQ-017 SHALL commit Put data at the acceptance edge, writing only bytes whose a_bits_mask bit is 1.
REQ-018 SHALL read Get data at the acceptance edge, returning all 8 bytes including the effect of any prior completed Put.
REQ-019 SHALL echo d_bits_source and d_bits_size from the request; d_bits_param=0, d_bits_sink=0.
REQ-020 SHALL drive d_bits_corrupt=1 only for denied Get responses; d_bits_data=0 whenever denied=1 or opcode=AccessAck.
REQ-021 SHALL increment txn_count on every D handshake and err_count when that response has denied=1; both wrap at max.
REQ-022 SHALL ignore a_valid in WAIT and RESP (no latch, no write).

Reset
REQ-023 SHALL on reset: FSM=IDLE, a_ready=0 during reset, d_valid=0, all d_bits=0, counters=0.
REQ-024 SHALL on reset mid-WAIT or mid-RESP abandon the pending response with no D handshake; a Put already committed stays in memory.
REQ-025 SHALL NOT clear memory contents on reset.

Configuration
REQ-026 SHALL honour macro TLUL_RESP_RANGE_CHECK_EN: when defined, addresses outside [BASE_ADDR, BASE_ADDR+MEM_DEPTH*8) are denied per REQ-020, with no memory access.
REQ-027 SHALL without TLUL_RESP_RANGE_CHECK_EN perform no range check; out-of-window addresses alias per REQ-016.

Verification
REQ-028 SHALL cover: PutFullData addr 0x8000_0010, mask 0xFF, data 0x1122334455667788, then Get same addr -> AccessAck, then AccessAckData data 0x1122334455667788, denied=0.
REQ-029 SHALL cover: PutPartialData addr 0x8000_0010, mask 0x0F, data 0xAAAAAAAA_BBBBBBBB after REQ-028 -> Get returns 0x11223344_BBBBBBBB.
REQ-030 SHALL cover: accept at cycle T, RESP_LATENCY=2, d_ready low 3 cycles -> d_valid high from T+2, fields stable, a_ready low until cycle after handshake.
REQ-031 SHALL cover: opcode 2 (ArithmeticData) and Get with size=4 -> denied=1, err_count=2, memory unchanged.
REQ-032 SHALL cover: Get addr 0x9000_0000 -> with TLUL_RESP_RANGE_CHECK_EN denied=1, corrupt=1; without it returns word 0 contents.
REQ-033 SHALL cover: reset asserted one cycle in WAIT -> d_valid stays 0, txn_count=0, a_ready=1 cycle after reset deasserts.
